// File: rtl/regfile_rename.sv
// Architectural register file with ROB rename tags: tracks the pending producer
// nick per register, retires committed values and answers dual-operand lookups.
module regfile_rename #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NAME_W = 5,
  parameter int unsigned NICK_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iCLR,
  input  logic              iROB_nick_en,
  input  logic [NICK_W-1:0] iROB_nick,
  input  logic [NAME_W-1:0] iROB_nick_regnm,
  input  logic              iRF_en,
  input  logic [NAME_W-1:0] iRF_rd_regnm,
  input  logic [DATA_W-1:0] iRF_rd_dt,
  input  logic [NICK_W-1:0] iRF_rd_nick,
  input  logic              iDP_en,
  input  logic [NAME_W-1:0] iDP_rs1_regnm,
  input  logic [NAME_W-1:0] iDP_rs2_regnm,
  output logic              oDP_vld,
  output logic [DATA_W-1:0] oDP_rs1_dt,
  output logic [DATA_W-1:0] oDP_rs2_dt,
  output logic [NICK_W-1:0] oDP_rs1_nick,
  output logic [NICK_W-1:0] oDP_rs2_nick
);

  localparam int unsigned NREGS = 1 << NAME_W;
  localparam int unsigned RES_W = NICK_W + DATA_W;

  logic [DATA_W-1:0] data_q [NREGS];
  logic [NICK_W-1:0] tag_q  [NREGS];
  logic [NREGS-1:0]  busy_q;

  logic             ren_c;
  logic             cmt_c;
  logic             ren_cmt_same_c;
  logic [RES_W-1:0] rs1_res_c;
  logic [RES_W-1:0] rs2_res_c;

  // x0 is never renamed or written, so it stays not-busy with data 0
  assign ren_c          = iROB_nick_en && (iROB_nick_regnm != '0);
  assign cmt_c          = iRF_en && (iRF_rd_regnm != '0);
  assign ren_cmt_same_c = ren_c && (iROB_nick_regnm == iRF_rd_regnm);

  // Operand resolution on pre-edge state; a same-cycle matching commit bypasses
  function automatic logic [RES_W-1:0] lookup(input logic [NAME_W-1:0] r);
    logic [RES_W-1:0] res;
    if (!busy_q[r]) begin
      res = {NICK_W'(0), data_q[r]};
    end else if (cmt_c && (iRF_rd_regnm == r) && (iRF_rd_nick == tag_q[r])) begin
      res = {NICK_W'(0), iRF_rd_dt};
    end else begin
      res = {tag_q[r], DATA_W'(0)};
    end
    return res;
  endfunction

  assign rs1_res_c = lookup(iDP_rs1_regnm);
  assign rs2_res_c = lookup(iDP_rs2_regnm);

  // Register state: commit data always lands; flush wipes all rename state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (cmt_c) data_q[iRF_rd_regnm] <= iRF_rd_dt;
      if (iCLR) begin
        busy_q <= '0;
        for (int i = 0; i < NREGS; i++) tag_q[i] <= '0;
      end else begin
        if (cmt_c && !ren_cmt_same_c && (tag_q[iRF_rd_regnm] == iRF_rd_nick))
          busy_q[iRF_rd_regnm] <= 1'b0;
        if (ren_c) begin
          busy_q[iROB_nick_regnm] <= 1'b1;
          tag_q[iROB_nick_regnm]  <= iROB_nick;
        end
      end
    end
  end

  // Registered lookup response; payload holds while no result is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oDP_vld      <= 1'b0;
      oDP_rs1_dt   <= '0;
      oDP_rs2_dt   <= '0;
      oDP_rs1_nick <= '0;
      oDP_rs2_nick <= '0;
    end else if (rdy) begin
      oDP_vld <= iDP_en && !iCLR;
      if (iDP_en && !iCLR) begin
        {oDP_rs1_nick, oDP_rs1_dt} <= rs1_res_c;
        {oDP_rs2_nick, oDP_rs2_dt} <= rs2_res_c;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed, table-driven bench for regfile_rename.
module tb_regfile_rename;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NAME_W = 5;
  localparam int unsigned NICK_W = 5;
  localparam int unsigned NVEC   = 23;

  logic              clk = 1'b0;
  logic              rst, rdy, iCLR;
  logic              iROB_nick_en, iRF_en, iDP_en;
  logic [NICK_W-1:0] iROB_nick, iRF_rd_nick;
  logic [NAME_W-1:0] iROB_nick_regnm, iRF_rd_regnm, iDP_rs1_regnm, iDP_rs2_regnm;
  logic [DATA_W-1:0] iRF_rd_dt;
  logic              oDP_vld;
  logic [DATA_W-1:0] oDP_rs1_dt, oDP_rs2_dt;
  logic [NICK_W-1:0] oDP_rs1_nick, oDP_rs2_nick;

  int checks = 0;
  int errors = 0;

  regfile_rename #(.DATA_W(DATA_W), .NAME_W(NAME_W), .NICK_W(NICK_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iCLR(iCLR),
    .iROB_nick_en(iROB_nick_en), .iROB_nick(iROB_nick), .iROB_nick_regnm(iROB_nick_regnm),
    .iRF_en(iRF_en), .iRF_rd_regnm(iRF_rd_regnm), .iRF_rd_dt(iRF_rd_dt), .iRF_rd_nick(iRF_rd_nick),
    .iDP_en(iDP_en), .iDP_rs1_regnm(iDP_rs1_regnm), .iDP_rs2_regnm(iDP_rs2_regnm),
    .oDP_vld(oDP_vld), .oDP_rs1_dt(oDP_rs1_dt), .oDP_rs2_dt(oDP_rs2_dt),
    .oDP_rs1_nick(oDP_rs1_nick), .oDP_rs2_nick(oDP_rs2_nick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rdy, clr;
    int ren, rreg, rnick;
    int cen, creg, cnick;
    int cdt;
    int den, rs1, rs2;
    int e_vld, e1dt, e1n, e2dt, e2n;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; iCLR = 1'b0;
    iROB_nick_en = 1'b0; iROB_nick = '0; iROB_nick_regnm = '0;
    iRF_en = 1'b0; iRF_rd_regnm = '0; iRF_rd_dt = '0; iRF_rd_nick = '0;
    iDP_en = 1'b0; iDP_rs1_regnm = '0; iDP_rs2_regnm = '0;
  endtask

  task automatic check_outputs(input string tag, input int vld, input int d1, input int n1,
                               input int d2, input int n2);
    check({tag, ".vld"},  32'(oDP_vld),      32'(vld));
    check({tag, ".rs1dt"}, oDP_rs1_dt,       32'(d1));
    check({tag, ".rs1n"},  32'(oDP_rs1_nick), 32'(n1));
    check({tag, ".rs2dt"}, oDP_rs2_dt,       32'(d2));
    check({tag, ".rs2n"},  32'(oDP_rs2_nick), 32'(n2));
  endtask

  initial begin
    //            rdy clr ren rreg rnick cen creg cnick cdt           den rs1 rs2 vld e1dt          e1n e2dt          e2n
    vecs[0]  = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  5,  0,  1,  0,            0,  0,            0};
    vecs[1]  = '{1, 0,  1,  3,  7,  0,  0,  0,  0,            0,  0,  0,  0,  0,            0,  0,            0};
    vecs[2]  = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  3,  0,  1,  0,            7,  0,            0};
    vecs[3]  = '{1, 0,  0,  0,  0,  1,  3,  7,  'hDEADBEEF,   1,  3,  3,  1,  'hDEADBEEF,   0,  'hDEADBEEF,   0};
    vecs[4]  = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  3,  5,  1,  'hDEADBEEF,   0,  0,            0};
    vecs[5]  = '{1, 0,  1,  4,  2,  0,  0,  0,  0,            0,  0,  0,  0,  'hDEADBEEF,   0,  0,            0};
    vecs[6]  = '{1, 0,  1,  4,  9,  0,  0,  0,  0,            0,  0,  0,  0,  'hDEADBEEF,   0,  0,            0};
    vecs[7]  = '{1, 0,  0,  0,  0,  1,  4,  2,  'h11,         1,  4,  3,  1,  0,            9,  'hDEADBEEF,   0};
    vecs[8]  = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  4,  0,  1,  0,            9,  0,            0};
    vecs[9]  = '{1, 0,  0,  0,  0,  1,  4,  9,  'h22,         0,  0,  0,  0,  0,            9,  0,            0};
    vecs[10] = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  4,  4,  1,  'h22,         0,  'h22,         0};
    vecs[11] = '{1, 0,  1,  6,  5,  0,  0,  0,  0,            0,  0,  0,  0,  'h22,         0,  'h22,         0};
    vecs[12] = '{1, 0,  1,  6,  8,  1,  6,  5,  'h55,         1,  6,  4,  1,  'h55,         0,  'h22,         0};
    vecs[13] = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  6,  0,  1,  0,            8,  0,            0};
    vecs[14] = '{1, 0,  1,  1,  10, 0,  0,  0,  0,            0,  0,  0,  0,  0,            8,  0,            0};
    vecs[15] = '{1, 0,  1,  2,  11, 0,  0,  0,  0,            1,  1,  2,  1,  0,            10, 0,            0};
    vecs[16] = '{1, 1,  1,  5,  12, 1,  1,  3,  'h77,         1,  1,  2,  0,  0,            10, 0,            0};
    vecs[17] = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  1,  2,  1,  'h77,         0,  0,            0};
    vecs[18] = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            0,  0,  0,  0,  'h77,         0,  0,            0};
    vecs[19] = '{0, 0,  1,  7,  3,  1,  5,  0,  'h99,         1,  7,  5,  0,  'h77,         0,  0,            0};
    vecs[20] = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  7,  5,  1,  0,            0,  0,            0};
    vecs[21] = '{1, 0,  1,  0,  4,  1,  0,  0,  'h99,         1,  0,  0,  1,  0,            0,  0,            0};
    vecs[22] = '{1, 0,  0,  0,  0,  0,  0,  0,  0,            1,  0,  7,  1,  0,            0,  0,            0};

    idle_inputs();
    rst = 1'b1;
    #12;
    check_outputs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      rdy             = 1'(vecs[i].rdy);
      iCLR            = 1'(vecs[i].clr);
      iROB_nick_en    = 1'(vecs[i].ren);
      iROB_nick_regnm = NAME_W'(vecs[i].rreg);
      iROB_nick       = NICK_W'(vecs[i].rnick);
      iRF_en          = 1'(vecs[i].cen);
      iRF_rd_regnm    = NAME_W'(vecs[i].creg);
      iRF_rd_nick     = NICK_W'(vecs[i].cnick);
      iRF_rd_dt       = DATA_W'(vecs[i].cdt);
      iDP_en          = 1'(vecs[i].den);
      iDP_rs1_regnm   = NAME_W'(vecs[i].rs1);
      iDP_rs2_regnm   = NAME_W'(vecs[i].rs2);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e1dt, vecs[i].e1n,
                    vecs[i].e2dt, vecs[i].e2n);
    end

    // Asynchronous reset mid-operation clears a presented result and all state
    idle_inputs();
    iDP_en = 1'b1; iDP_rs1_regnm = NAME_W'(3); iDP_rs2_regnm = NAME_W'(1);
    @(negedge clk);
    check_outputs("pre_rst", 1, 'hDEADBEEF, 0, 'h77, 0);
    iDP_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    iDP_en = 1'b1; iDP_rs1_regnm = NAME_W'(3); iDP_rs2_regnm = NAME_W'(1);
    @(negedge clk);
    check_outputs("post_rst", 1, 0, 0, 0, 0);

    // Commit with matching tag clears busy even while another register is renamed
    idle_inputs();
    iROB_nick_en = 1'b1; iROB_nick_regnm = NAME_W'(9); iROB_nick = NICK_W'(4);
    @(negedge clk);
    iROB_nick_regnm = NAME_W'(10); iROB_nick = NICK_W'(6);
    iRF_en = 1'b1; iRF_rd_regnm = NAME_W'(9); iRF_rd_nick = NICK_W'(4); iRF_rd_dt = 32'hCAFE0009;
    @(negedge clk);
    idle_inputs();
    iDP_en = 1'b1; iDP_rs1_regnm = NAME_W'(9); iDP_rs2_regnm = NAME_W'(10);
    @(negedge clk);
    check_outputs("cross_reg", 1, 'hCAFE0009, 0, 0, 6);
    iDP_en = 1'b0;
    @(negedge clk);
    check("vld_pulse", 32'(oDP_vld), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
# regfile_rename

Architectural register file with rename tags for the out-of-order RISC-V core. It is the consumer of the ROB's rename-announce and commit-writeback interfaces. It records which ROB nick will produce each register and retires committed values into architectural state. It answers dispatch operand lookups with either a ready value or the pending nick, and drops all rename state on a misprediction flush.

## Interface
- `DATA_W`, default 32: register data width.
- `NAME_W`, default 5: architectural register index width (x0..x31).
- `NICK_W`, default 5: ROB nick width. Nick 0 means "no tag / value ready"; valid nicks are 1..31.

- `clk`  in  1  clock.
- `rst`  in  1  **one clock; reset is asynchronous and active-high.**
- `rdy`  in  1  global enable. When low, all state and outputs hold and all inputs are ignored.
- `iCLR`  in  1  flush from the ROB on misprediction.
- `iROB_nick_en`  in  1  rename announce valid.
- `iROB_nick`  in  NICK_W  nick allocated to the instruction.
- `iROB_nick_regnm`  in  NAME_W  destination register of that instruction.
- `iRF_en`  in  1  commit writeback valid.
- `iRF_rd_regnm`  in  NAME_W  committed destination register.
- `iRF_rd_dt`  in  DATA_W  committed value.
- `iRF_rd_nick`  in  NICK_W  nick of the committing entry.
- `iDP_en`  in  1  operand lookup request.
- `iDP_rs1_regnm`, `iDP_rs2_regnm`  in  NAME_W  source registers.
- `oDP_vld`  out  1  lookup result valid.
- `oDP_rs1_dt`, `oDP_rs2_dt`  out  DATA_W  operand value; meaningful only when the matching nick is 0.
- `oDP_rs1_nick`, `oDP_rs2_nick`  out  NICK_W  pending producer nick, or 0 when the value is ready.

## Operation
- **State per register r:** `data[r]` (DATA_W), `busy[r]` (1 bit), `tag[r]` (NICK_W).
- **x0:** never busy, always reads 0. Renames and commits targeting x0 are ignored.
- **Rename** (`iROB_nick_en`, regnm ≠ 0): `busy[regnm]` ← 1 and `tag[regnm]` ← `iROB_nick`. A later rename of the same register overwrites the tag (newest producer wins).
- **Commit** (`iRF_en`, regnm ≠ 0):
  - `data[regnm]` ← `iRF_rd_dt`, unconditionally.
  - `busy[regnm]` ← 0 only if `tag[regnm]` == `iRF_rd_nick` and there is no same-cycle rename of the same register.
  - If the tag does not match, a younger producer exists: data is written and busy/tag are unchanged.
- **Same-cycle rename and commit, same register:** data takes the commit value; tag takes the new nick; busy stays 1.
- **Lookup:** a request sampled at edge N is answered in the registered outputs after edge N. Per operand, evaluated on pre-edge state:
  - Not busy → value = `data[r]`, nick = 0.
  - Busy, with a same-cycle commit of the same register whose nick == `tag[r]` → value = `iRF_rd_dt`, nick = 0 (commit bypass).
  - Busy otherwise → nick = `tag[r]`, value = 0.
  - A same-cycle rename never affects the lookup. Lookups see the mapping from before that rename, so an instruction with rs == rd reads the older producer.
- **Flush** (`iCLR`):
  - All `busy` cleared and all `tag` set to 0 in that cycle.
  - A same-cycle commit still writes data.
  - A same-cycle rename is discarded.
  - A same-cycle lookup is dropped: `oDP_vld` = 0 next cycle.
- **Priority per edge:** `rst` > `!rdy` (hold) > `iCLR` > rename/commit/lookup.

## Timing
- **Reset (asynchronous):** all `data`, `busy`, `tag` = 0. `oDP_vld` = 0. All `oDP_*` data and nick outputs = 0.
- **Lookup latency:** 1 cycle. `oDP_vld` is high for exactly one cycle per accepted `iDP_en` and is 0 otherwise; the data and nick outputs hold their last values while `oDP_vld` = 0.
- **Rename visibility:** a rename at edge N is visible to lookups sampled at edge N+1 onward.
- **Commit visibility:** a commit at edge N is visible via bypass to lookups at edge N, and via state from N+1.
- **Throughput:** one rename, one commit and one dual-operand lookup every cycle. There is no back-pressure.
- **Reset mid-operation:** takes effect immediately. Any pending `oDP_vld` is cleared.

## Test plan
- **Reset then lookup:** reset, then look up x5/x0 → `oDP_vld` = 1 one cycle later; dt = 0/0; nick = 0/0.
- **Rename then commit:** rename x3 → nick 7; look up x3 → nick 7. Commit x3, nick 7, dt 0xDEADBEEF; look up x3 → dt 0xDEADBEEF, nick 0.
- **Stale commit:** rename x4 → nick 2, then x4 → nick 9. Commit x4, nick 2, dt 0x11 → lookup returns nick 9. Commit x4, nick 9, dt 0x22 → lookup returns dt 0x22, nick 0.
- **Same-cycle events:** with x6 busy at nick 5, issue in one cycle a commit x6 (nick 5, dt 0x55), a rename x6 → nick 8, and a lookup of rs1 = x6 → lookup returns dt 0x55, nick 0. The next lookup returns nick 8.
- **Flush:** with x1, x2 busy, assert `iCLR` together with commit x1 (dt 0x77, stale nick) and a lookup. Required: `oDP_vld` = 0 next cycle; later lookup of x1 → dt 0x77, nick 0; x2 → nick 0.
- **rdy stall:** hold `rdy` = 0 while driving rename x7 → nick 3 and a lookup → no `oDP_vld` pulse, and x7 is still ready after `rdy` returns high. A write to x0 leaves x0 reading 0.
